// File: rtl/mm2st.sv
// mm2st: reads pkt_len words from RAM over Avalon-MM and streams them out as one Avalon-ST packet.
// Define MM2ST_PKTCNT_EN to add the pkt_count output (count of completed packets).
module mm2st #(
  parameter int BITSIZE    = 32,
  parameter int EMPTY_SIZE = 2,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MM2ST_PKTCNT_EN
  output logic [15:0]           pkt_count,
`endif
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   pkt_len,
  input  logic [EMPTY_SIZE-1:0] last_empty,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mm_address,
  output logic                  mm_chipselect,
  output logic                  mm_read,
  input  logic [BITSIZE-1:0]    mm_readdata,
  input  logic                  mm_waitrequest_n,
  output logic [BITSIZE-1:0]    st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_startofpacket,
  output logic                  st_endofpacket,
  output logic [EMPTY_SIZE-1:0] st_empty
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     len_q, len_d, issued_q, issued_d, beat_q, beat_d;
  logic [EMPTY_SIZE-1:0]   empty_q, empty_d;
  logic                    inflight_q, inflight_d, wr_q, wr_d, rd_q, rd_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [BITSIZE-1:0]      mem_q [2];
  logic [BITSIZE-1:0]      mem_d [2];
  logic                    accept, pop, eop;
`ifdef MM2ST_PKTCNT_EN
  logic [15:0]             pkt_count_q, pkt_count_d;
  assign pkt_count = pkt_count_q;
`endif
  assign busy             = busy_q;
  assign done             = done_q;
  assign mm_address       = issued_q[ADDR_WIDTH-1:0];
  assign mm_chipselect    = mm_read;
  assign st_valid         = cnt_q != 2'd0;
  assign st_data          = mem_q[rd_q];
  assign eop              = st_valid && beat_q == len_q - ONE;
  assign st_startofpacket = st_valid && beat_q == '0;
  assign st_endofpacket   = eop;
  assign st_empty         = eop ? empty_q : '0;
  assign pop              = st_valid && st_ready;
  // Credit counts words already buffered or in flight, so the 2-entry FIFO can never overflow.
  assign mm_read = state_q == READ && issued_q < len_q &&
                   ({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
  assign accept  = mm_read && mm_waitrequest_n;
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    empty_d    = empty_q;
    issued_d   = accept ? issued_q + ONE : issued_q;
    beat_d     = pop ? beat_q + ONE : beat_q;
    inflight_d = accept;
    mem_d      = mem_q;
    wr_d       = inflight_q ? ~wr_q : wr_q;
    rd_d       = pop ? ~rd_q : rd_q;
    cnt_d      = (inflight_q && !pop) ? cnt_q + 2'd1 :
                 (!inflight_q && pop) ? cnt_q - 2'd1 : cnt_q;
    if (inflight_q) mem_d[wr_q] = mm_readdata;
    case (state_q)
      IDLE: if (start && pkt_len != '0) begin
        state_d  = READ;
        len_d    = pkt_len;
        empty_d  = last_empty;
        issued_d = '0;
        beat_d   = '0;
      end
      READ:    if (accept && issued_q + ONE == len_q) state_d = DRAIN;
      DRAIN:   if (pop && eop) state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d == READ || state_d == DRAIN;
    done_d = state_d == DONE;
`ifdef MM2ST_PKTCNT_EN
    pkt_count_d = done_d ? pkt_count_q + 16'd1 : pkt_count_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      empty_q    <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
`ifdef MM2ST_PKTCNT_EN
      pkt_count_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      empty_q    <= empty_d;
      issued_q   <= issued_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
`ifdef MM2ST_PKTCNT_EN
      pkt_count_q <= pkt_count_d;
`endif
    end
  end
endmodule

// File: tb/tb_mm2st.sv
// tb_mm2st: directed bench for mm2st with a latency-1 RAM model and a beat/read monitor.
module tb_mm2st;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, mm_chipselect, mm_read, mm_waitrequest_n;
  logic [9:0]  pkt_len;
  logic [1:0]  last_empty, st_empty;
  logic [8:0]  mm_address;
  logic [31:0] mm_readdata, st_data;
  logic        st_valid, st_ready, st_startofpacket, st_endofpacket;
`ifdef MM2ST_PKTCNT_EN
  logic [15:0] pkt_count;
`endif
  logic [31:0] ram [512];
  logic [31:0] dq [$];
  logic [3:0]  fq [$];
  logic [8:0]  addrs [$];
  int checks = 0, errors = 0, pauses = 0, max_out = 0, cur_len = 0, done_cnt = 0;

  mm2st dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MM2ST_PKTCNT_EN
    .pkt_count(pkt_count),
`endif
    .start(start), .pkt_len(pkt_len), .last_empty(last_empty), .busy(busy), .done(done),
    .mm_address(mm_address), .mm_chipselect(mm_chipselect), .mm_read(mm_read),
    .mm_readdata(mm_readdata), .mm_waitrequest_n(mm_waitrequest_n),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_startofpacket(st_startofpacket), .st_endofpacket(st_endofpacket), .st_empty(st_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mm_read && mm_waitrequest_n) mm_readdata <= ram[mm_address];

  initial forever begin
    @(negedge clk);
    if (mm_read && mm_waitrequest_n) addrs.push_back(mm_address);
    if (st_valid && st_ready) begin
      dq.push_back(st_data);
      fq.push_back({st_startofpacket, st_endofpacket, st_empty});
    end
    if (done) done_cnt++;
    if (busy && !mm_read && addrs.size() < cur_len) pauses++;
    if (addrs.size() - dq.size() > max_out) max_out = addrs.size() - dq.size();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_pkt(input int len, input logic [1:0] emp, input int mode, input bit restart);
    int stalls = 0, bad = 0, abad = 0;
    bit got = 0, prev_stall = 0;
    logic [3:0] ef;
    dq.delete(); fq.delete(); addrs.delete();
    pauses = 0; max_out = 0; cur_len = len;
    @(posedge clk); #1 start = 1'b1; pkt_len = len[9:0]; last_empty = emp;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1 start = 1'b0;
      if (restart && c == 2) begin start = 1'b1; pkt_len = 10'd5; end
      if (prev_stall) chk("addr_hold", {23'd0, mm_address}, 32'd1);
      prev_stall = 0;
      if (mode == 2 && mm_read && mm_address == 9'd1 && stalls < 3) begin
        mm_waitrequest_n = 1'b0; stalls++; prev_stall = 1;
      end else mm_waitrequest_n = 1'b1;
      st_ready = (mode == 1) ? ~st_ready : 1'b1;
      if (done) begin got = 1; break; end
    end
    start = 1'b0; st_ready = 1'b1; mm_waitrequest_n = 1'b1;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("beat_count", dq.size(), len);
    chk("read_count", addrs.size(), len);
    for (int i = 0; i < dq.size(); i++) begin
      ef = {i == 0, i == len - 1, (i == len - 1) ? emp : 2'd0};
      if (dq[i] !== 32'hA0 + i || fq[i] !== ef) bad++;
    end
    for (int i = 0; i < addrs.size(); i++) if (addrs[i] !== 9'(i)) abad++;
    chk("beat_errs", bad, 0);
    chk("addr_errs", abad, 0);
    chk("no_overflow", {31'd0, max_out <= 2}, 32'd1);
    if (mode == 2) chk("stalls", stalls, 3);
  endtask

  initial begin
    bit busy_seen;
    for (int i = 0; i < 512; i++) ram[i] = 32'hA0 + i;
    rst_n = 1'b0; start = 1'b0; pkt_len = '0; last_empty = '0;
    st_ready = 1'b1; mm_waitrequest_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_read", {30'd0, mm_read, mm_chipselect}, 0);
    chk("rst_valid", {28'd0, st_valid, st_startofpacket, st_endofpacket, done}, 0);
    chk("rst_addr_empty", {21'd0, mm_address, st_empty}, 0);
    rst_n = 1'b1;
    // Cycle-exact packet: first beat two cycles after the start edge.
    dq.delete(); fq.delete(); addrs.delete();
    @(posedge clk); #1 start = 1'b1; pkt_len = 10'd4; last_empty = 2'd2;
    @(posedge clk); #1 start = 1'b0;
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_read", {31'd0, mm_read}, 1);
    chk("t1_valid0", {31'd0, st_valid}, 0);
    @(posedge clk); #1;
    chk("t1_valid1", {31'd0, st_valid}, 0);
    chk("t1_addr1", {23'd0, mm_address}, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t1_valid", {31'd0, st_valid}, 1);
      chk("t1_data", st_data, 32'hA0 + i);
      chk("t1_flags", {28'd0, st_startofpacket, st_endofpacket, st_empty},
          {28'd0, i == 0, i == 3, (i == 3) ? 2'd2 : 2'd0});
    end
    @(posedge clk); #1;
    chk("t1_done", {30'd0, done, busy}, 32'b10);
    @(posedge clk); #1;
    chk("t1_done_pulse", {31'd0, done}, 0);
    chk("t1_reads", addrs.size(), 4);
    run_pkt(8, 2'd1, 1, 0);
    chk("t2_paused", {31'd0, pauses != 0}, 1);
    run_pkt(3, 2'd3, 2, 0);
`ifdef MM2ST_PKTCNT_EN
    chk("pkt_count3", {16'd0, pkt_count}, 3);
`endif
    run_pkt(1, 2'd3, 0, 0);
    addrs.delete(); busy_seen = 0;
    @(posedge clk); #1 start = 1'b1; pkt_len = 10'd0;
    repeat (6) begin
      @(posedge clk); #1 start = 1'b0;
      busy_seen |= busy;
    end
    chk("len0_busy", {31'd0, busy_seen}, 0);
    chk("len0_reads", addrs.size(), 0);
    done_cnt = 0;
    run_pkt(4, 2'd0, 0, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("restart_beats", dq.size(), 4);
    chk("restart_dones", done_cnt, 1);
    chk("restart_idle", {31'd0, busy}, 0);
    run_pkt(512, 2'd1, 0, 0);
    chk("sweep_last_addr", {23'd0, addrs[$]}, 511);
    @(posedge clk); #1 start = 1'b1; pkt_len = 10'd8;
    repeat (4) begin @(posedge clk); #1 start = 1'b0; end
    chk("mid_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {28'd0, busy, done, mm_read, mm_chipselect}, 0);
    chk("arst_st", {29'd0, st_valid, st_startofpacket, st_endofpacket}, 0);
    chk("arst_addr_empty", {21'd0, mm_address, st_empty}, 0);
`ifdef MM2ST_PKTCNT_EN
    chk("pkt_count_rst", {16'd0, pkt_count}, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    run_pkt(6, 2'd2, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
